// File: rtl/usb_fifo_writer.sv
// ============================================================================
// Module   : usb_fifo_writer
// Purpose  : Frames FFT result words (header, frame number, data, pad to a
//            whole USB packet) and writes them into the Cypress FX2 slave
//            FIFO, throttled by the registered FX2 full flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_fifo_writer #(
  parameter int unsigned PKT_WORDS = 256,
  parameter logic [15:0] HDR_WORD  = 16'hA55A,
  parameter logic [15:0] PAD_WORD  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        flaga,
  output logic [15:0] fd,
  output logic        slwr,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int unsigned PW = $clog2(PKT_WORDS);
  localparam logic [PW-1:0] PKT_ONE = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    FNUM = 3'd2,
    DATA = 3'd3,
    PAD  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          flaga_q;
  logic [15:0]   fd_q;
  logic          slwr_q;
  logic [PW-1:0] pkt_cnt;
  logic [PW-1:0] pkt_inc;
  logic          issue;
  logic [15:0]   issue_word;
  logic          frame_done;

  // Packet position after the word being issued this cycle; zero means the
  // packet closes with this word.
  assign pkt_inc = pkt_cnt + PKT_ONE;

  assign fd   = fd_q;
  assign slwr = slwr_q;
  assign busy = (state != IDLE);

  // Next-state, issue decision and s_ready; every write is gated by flaga_q.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_word = fd_q;
    s_ready    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) state_next = HDR;
      end
      HDR: begin
        if (flaga_q) begin
          issue      = 1'b1;
          issue_word = HDR_WORD;
          state_next = FNUM;
        end
      end
      FNUM: begin
        if (flaga_q) begin
          issue      = 1'b1;
          issue_word = frame_cnt;
          state_next = DATA;
        end
      end
      DATA: begin
        // Ready depends only on state and flaga_q, never on s_valid.
        s_ready = flaga_q;
        if (flaga_q && s_valid) begin
          issue      = 1'b1;
          issue_word = s_data;
          if (s_last) begin
            if (pkt_inc == '0) begin
              state_next = IDLE;
              frame_done = 1'b1;
            end else begin
              state_next = PAD;
            end
          end
        end
      end
      PAD: begin
        if (flaga_q) begin
          issue      = 1'b1;
          issue_word = PAD_WORD;
          if (pkt_inc == '0) begin
            state_next = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, full-flag register and the registered FX2 pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flaga_q   <= 1'b0;
      fd_q      <= 16'h0000;
      slwr_q    <= 1'b1;
      pkt_cnt   <= '0;
      frame_cnt <= 16'h0000;
    end else begin
      state   <= state_next;
      flaga_q <= flaga;
      slwr_q  <= ~issue;
      if (issue) begin
        fd_q    <= issue_word;
        pkt_cnt <= pkt_inc;
      end
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_fifo_writer.sv
// ============================================================================
// Module   : tb_usb_fifo_writer
// Purpose  : Directed self-checking bench for usb_fifo_writer (PKT_WORDS=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_fifo_writer;

  localparam int          PKT  = 8;
  localparam logic [15:0] HDRW = 16'hA55A;
  localparam logic [15:0] PADW = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        flaga;
  logic [15:0] fd;
  logic        slwr;
  logic [15:0] frame_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [15:0] cap[$];

  usb_fifo_writer #(
    .PKT_WORDS(PKT),
    .HDR_WORD (HDRW),
    .PAD_WORD (PADW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .flaga    (flaga),
    .fd       (fd),
    .slwr     (slwr),
    .frame_cnt(frame_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Record every word strobed onto the FX2 bus.
  always @(negedge clk) begin
    if (!slwr) cap.push_back(fd);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present_and_accept(input logic [15:0] d, input logic last);
    bit acc;
    int t;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 100) begin
      acc = s_ready;
      @(negedge clk);
      t++;
    end
    chk($sformatf("accept_%h", d), {31'd0, acc}, 32'd1);
    acc_cnt++;
  endtask

  task automatic send_frame(input int n, input logic [15:0] base, input int stall_at,
                            input int stall_len, input int exp_strobes,
                            input logic [15:0] fn);
    logic [15:0] exp[$];
    logic [15:0] fn_next;
    int bad_r;
    int bad_w;
    int t;
    cap.delete();
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < n; i++) present_and_accept(base + 16'(i), (i == n - 1));
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      begin
        if (stall_len > 0) begin
          t = 0;
          while (acc_cnt < stall_at && t < 200) begin
            @(negedge clk);
            t++;
          end
          flaga = 1'b0;
          bad_r = 0;
          bad_w = 0;
          for (int j = 1; j <= stall_len; j++) begin
            @(negedge clk);
            if (s_ready) bad_r++;
            if (j >= 2 && !slwr) bad_w++;
          end
          flaga = 1'b1;
          chk("stall_s_ready", bad_r, 0);
          chk("stall_slwr", bad_w, 0);
        end
      end
    join
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("frame_end_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    exp.push_back(HDRW);
    exp.push_back(fn);
    for (int i = 0; i < n; i++) exp.push_back(base + 16'(i));
    while (exp.size() % PKT != 0) exp.push_back(PADW);
    chk($sformatf("strobe_count_n%0d", n), cap.size(), exp_strobes);
    for (int k = 0; k < exp.size(); k++) begin
      if (k < cap.size()) chk($sformatf("word%0d_n%0d", k, n), {16'd0, cap[k]}, {16'd0, exp[k]});
    end
    fn_next = fn + 16'd1;
    chk($sformatf("frame_cnt_n%0d", n), {16'd0, frame_cnt}, {16'd0, fn_next});
  endtask

  typedef struct {
    int          n;
    logic [15:0] base;
    int          stall_at;
    int          stall_len;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{6,  16'h0101, -1, 0,  8};
    vecs[1] = '{4,  16'h0001, -1, 0,  8};
    vecs[2] = '{7,  16'h0201, -1, 0,  16};
    vecs[3] = '{12, 16'h0301, 5,  10, 16};
    vecs[4] = '{1,  16'h0401, -1, 0,  8};
    vecs[5] = '{14, 16'h0501, -1, 0,  16};
    vecs[6] = '{15, 16'h0601, 3,  4,  24};

    reset   = 1'b1;
    flaga   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_fd", {16'd0, fd}, 32'd0);
    chk("rst_slwr", {31'd0, slwr}, 32'd1);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Abort a frame with reset right after its 3rd data word is accepted.
    cap.delete();
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) present_and_accept(16'h0F00 + 16'(i), 1'b0);
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("abort_slwr", {31'd0, slwr}, 32'd1);
    chk("abort_fd", {16'd0, fd}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("abort_strobes", cap.size(), 5);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].n, vecs[v].base, vecs[v].stall_at, vecs[v].stall_len,
                 vecs[v].exp_strobes, 16'(v));
    end

    // Frame counter wrap: frame number FFFF is sent, then the count wraps.
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    send_frame(1, 16'h0701, -1, 0, 8, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
